// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised level readback, per-bit edge capture with
// write-to-clear, and a maskable level interrupt.
module pio_in_edge_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [CNT_W-1:0] prime_cnt;
  logic             armed;
  logic             wr;
  logic [31:0]      rd_mux;
  logic             wdata_unused;

  function automatic logic [WIDTH-1:0] edge_sel(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] old);
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    rise = cur & ~old;
    fall = ~cur & old;
    if (EDGE_TYPE == 0)      return rise;
    else if (EDGE_TYPE == 1) return fall;
    else                     return rise | fall;
  endfunction

  assign wr           = chipselect & ~write_n;
  assign sync_out     = sync[SYNC_STAGES-1];
  assign sel          = edge_sel(sync_out, prev);
  assign set_bits     = armed ? sel : '0;
  assign irq          = |(edgecapture & irqmask);
  assign wdata_unused = ^writedata;

  // Synchroniser chain and one-cycle-delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      prev <= '0;
    end else begin
      sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync_out;
    end
  end

  // Hold off capture until the chain has flushed its reset zeros, so pins
  // idling high do not look like rising edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= '0;
      armed     <= 1'b0;
    end else if (!armed) begin
      prime_cnt <= prime_cnt + CNT_W'(1);
      if (prime_cnt == CNT_W'(SYNC_STAGES)) armed <= 1'b1;
    end
  end

  always_comb begin
    clr_bits = '0;
    if (wr && address == 2'd3)
      clr_bits = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(sync_out);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecapture);
      default: rd_mux = '0;
    endcase
  end

  // Register file and read port; a new edge overrides a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr_bits) | set_bits;
      readdata    <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Directed bench for pio_in_edge_capture: three instances (rising/bit-clear,
// falling/bit-clear, any-edge/clear-all) share one bus and one input pin set.
module tb_pio_in_edge_capture;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_a, rd_b, rd_c;
  logic          irq_a, irq_b, irq_c;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    string       tag;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ec;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEAR(1)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(1), .BIT_CLEAR(1)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_b), .irq(irq_b));

  pio_in_edge_capture #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .BIT_CLEAR(0)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_c), .irq(irq_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
    exp_t e;
    e.tag = tag; e.ea = ea; e.eb = eb; e.ec = ec;
    sb.push_back(e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    e = sb.pop_front();
    check({e.tag, "/a"}, rd_a, e.ea);
    check({e.tag, "/b"}, rd_b, e.eb);
    check({e.tag, "/c"}, rd_c, e.ec);
  endtask

  task automatic chk_irq(input string tag, input logic ia, input logic ib, input logic ic);
    check({tag, "/a"}, 32'(irq_a), 32'(ia));
    check({tag, "/b"}, 32'(irq_b), 32'(ib));
    check({tag, "/c"}, 32'(irq_c), 32'(ic));
  endtask

  initial begin
    reset_n    = 1'b0;
    in_port    = 8'hFF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    cyc(2);
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_rd_c", rd_c, 32'h0);
    chk_irq("rst_irq", 1'b0, 1'b0, 1'b0);

    // Release with pins high: level appears after 3 clocks, no spurious capture
    reset_n = 1'b1;
    cyc(1);
    rd("data_early", 2'd0, 32'h00, 32'h00, 32'h00);
    rd("data_ff",    2'd0, 32'hFF, 32'hFF, 32'hFF);
    cyc(3);
    rd("prime_ec", 2'd3, 32'h00, 32'h00, 32'h00);
    chk_irq("prime_irq", 1'b0, 1'b0, 1'b0);

    in_port = 8'h00;
    cyc(4);
    rd("fall_ff", 2'd3, 32'h00, 32'hFF, 32'hFF);
    wr(2'd3, 32'hFF);
    rd("clr_all", 2'd3, 32'h00, 32'h00, 32'h00);
    wr(2'd2, 32'h05);
    rd("mask", 2'd2, 32'h05, 32'h05, 32'h05);

    // Rising 0x00 -> 0x0F
    in_port = 8'h0F;
    cyc(2);
    chk_irq("irq_before", 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_irq("irq_rise", 1'b1, 1'b0, 1'b1);
    rd("ec_rise", 2'd3, 32'h0F, 32'h00, 32'h0F);
    wr(2'd3, 32'h01);
    chk_irq("irq_clr1", 1'b1, 1'b0, 1'b0);
    rd("ec_clr1", 2'd3, 32'h0E, 32'h00, 32'h00);
    wr(2'd3, 32'h04);
    chk_irq("irq_clr4", 1'b0, 1'b0, 1'b0);
    rd("ec_clr4", 2'd3, 32'h0A, 32'h00, 32'h00);

    // Falling 0x0F -> 0x00
    in_port = 8'h00;
    cyc(3);
    chk_irq("irq_fall", 1'b0, 1'b1, 1'b1);
    rd("ec_fall", 2'd3, 32'h0A, 32'h0F, 32'h0F);
    wr(2'd3, 32'hFF);
    rd("ec_clr2", 2'd3, 32'h00, 32'h00, 32'h00);

    // Clear write lands on the same edge that captures bit 3
    in_port = 8'h08;
    cyc(2);
    wr(2'd3, 32'hFF);
    rd("ec_setwins", 2'd3, 32'h08, 32'h00, 32'h08);
    in_port = 8'h00;
    cyc(3);
    wr(2'd3, 32'hFF);
    rd("ec_clr3", 2'd3, 32'h00, 32'h00, 32'h00);

    // Zero write clears everything only on the clear-all instance
    in_port = 8'h33;
    cyc(3);
    rd("ec_33", 2'd3, 32'h33, 32'h00, 32'h33);
    wr(2'd3, 32'h00);
    rd("ec_wr0", 2'd3, 32'h33, 32'h00, 32'h00);
    rd("rsvd", 2'd1, 32'h0, 32'h0, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd("data_ro", 2'd0, 32'h33, 32'h33, 32'h33);
    rd("rsvd_ro", 2'd1, 32'h0, 32'h0, 32'h0);

    // Build up 0x55 with all bits unmasked, then reset mid-stream
    wr(2'd3, 32'hFF);
    in_port = 8'h00;
    cyc(3);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'hFF);
    in_port = 8'h55;
    cyc(3);
    rd("ec_55", 2'd3, 32'h55, 32'h00, 32'h55);
    chk_irq("irq_55", 1'b1, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rd_a", rd_a, 32'h0);
    check("async_rd_c", rd_c, 32'h0);
    chk_irq("async_irq", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(5);
    rd("rearm_gate", 2'd3, 32'h00, 32'h00, 32'h00);
    rd("mask_rst", 2'd2, 32'h00, 32'h00, 32'h00);
    chk_irq("irq_rst", 1'b0, 1'b0, 1'b0);
    in_port = 8'hFF;
    cyc(3);
    rd("ec_rearm", 2'd3, 32'hAA, 32'h00, 32'hAA);

    // Earliest capturable edge: change before edge 2 is sampled at edge 4
    reset_n = 1'b0;
    in_port = 8'h00;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    in_port = 8'h0F;
    cyc(3);
    rd("first_edge", 2'd3, 32'h0F, 32'h00, 32'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
